countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter with a run/expire state machine and a one-cycle terminal-count pulse. It is the decrementing counterpart of the incrementing program counter. Software or the controller loads a count and starts it. The block then counts down on each enabled clock and flags expiry until it is acknowledged. It serves as the processor's delay/loop timer alongside the datapath counters.

## Interface
- WIDTH, 5, count and load-value width

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset; asynchronous, active-low (0 = reset)
- cnt_in  input  WIDTH  value captured on load
- load  input  1  load cnt_in into count and reload register
- start  input  1  begin countdown (honoured only in IDLE)
- enab  input  1  decrement qualifier while running
- ack  input  1  acknowledge expiry (honoured only in EXPIRED)
- cnt_out  output  WIDTH  current count (registered)
- busy  output  1  high in RUN
- expired  output  1  high in EXPIRED
- tc  output  1  terminal-count pulse (registered, one cycle)

## Operation
- States: IDLE, RUN, EXPIRED; internal reload register `rld` (WIDTH bits).
- Reset (rst=0, any time, asynchronous): state IDLE, cnt_out=0, rld=0, tc=0, busy=0, expired=0.
- Priority per edge: reset > load > state-specific actions.
- load=1 (any state): cnt_out<=cnt_in, rld<=cnt_in, state<=IDLE, tc<=0. start/enab/ack ignored that cycle.
- IDLE:
  - start=1, cnt_out!=0 -> RUN.
  - start=1, cnt_out==0 -> EXPIRED, tc<=1.
  - Otherwise hold.
- RUN:
  - enab=1, cnt_out>1 -> cnt_out<=cnt_out-1.
  - enab=1, cnt_out==1 -> terminal event: tc<=1; remaining behaviour per Configuration.
  - enab=0 -> hold count. start ignored.
- EXPIRED: cnt_out holds 0. ack=1 -> IDLE, cnt_out<=rld. start and enab ignored.
- tc is 0 in every cycle not following a terminal event.
- Arithmetic: unsigned, modulo 2^WIDTH. Decrement never underflows, because RUN is never entered or kept with count 0.
- busy = (state==RUN); expired = (state==EXPIRED). Both decoded from registered state, no input-to-output paths.

## Timing
- start sampled at edge k: busy=1 after edge k. First decrement possible at edge k+1.
- Loaded value N, enab held high: cnt_out shows N-1 after edge k+1 and reaches 0 (or reload) after edge k+N. tc=1 and expired=1 during cycle k+N to k+N+1.
- Each enab=0 cycle in RUN delays expiry by exactly one cycle.
- ack at edge m: expired=0, cnt_out=rld after edge m.
- load during RUN aborts the run. Next cycle: busy=0, cnt_out=cnt_in.
- Reset deassertion: first active edge behaves as IDLE with count 0.

## Configuration
- COUNTDOWN_AUTORELOAD_EN defined: a RUN terminal event sets cnt_out<=rld and stays in RUN (periodic tc every rld enabled cycles). EXPIRED is reachable only via start with count 0.
- Not defined: a RUN terminal event sets cnt_out<=0 and moves to EXPIRED (one-shot).
- tc timing is identical in both builds.

## Test plan
- Reset state: rst=0 mid-RUN with count 4 -> immediately cnt_out=0, busy=0, expired=0, tc=0. After release, state is IDLE.
- One-shot run: load 3, start, enab=1 continuous -> cnt_out 3,2,1,0 on consecutive edges. tc high exactly one cycle with cnt_out=0, expired=1. ack -> cnt_out=3, IDLE.
- Enable gaps: load 2, start, enab pattern 1,0,0,1 -> cnt_out 2,1,1,1,0. tc on the 4th enabled-window edge only.
- Simultaneous events: in RUN at count 1, assert load (cnt_in=5) with enab=1 -> cnt_out=5, IDLE, tc=0. In IDLE, start with count 0 -> EXPIRED plus one tc pulse.
- Ignored inputs: start in RUN, ack in IDLE/RUN, enab in EXPIRED -> no state or count change.
- Autoreload build: load 2, start, enab=1 for 6 cycles -> cnt_out 2,1,2,1,2,1,2. tc pulses after edges 2, 4 and 6; expired stays 0.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with IDLE/RUN/EXPIRED control and one-cycle tc pulse
// Ports: clk, rst (async active-low), cnt_in (load value), load, start, enab (decrement qualifier),
//        ack (clears expiry), cnt_out (count), busy (RUN), expired (EXPIRED), tc (terminal pulse).
// Build option COUNTDOWN_AUTORELOAD_EN: terminal count reloads from rld and keeps running.
module countdown_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             load,
  input  logic             start,
  input  logic             enab,
  input  logic             ack,
  output logic [WIDTH-1:0] cnt_out,
  output logic             busy,
  output logic             expired,
  output logic             tc
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  state_t state;
  logic [WIDTH-1:0] rld;
  assign busy    = state == RUN;
  assign expired = state == EXPIRED;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt_out <= '0;
      rld     <= '0;
      tc      <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        cnt_out <= cnt_in;
        rld     <= cnt_in;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= cnt_out != '0 ? RUN : EXPIRED;
            tc    <= cnt_out == '0;
          end
          // RUN always holds a nonzero count, so the else branch is count==1
          RUN: if (enab) begin
            if (cnt_out > WIDTH'(1)) cnt_out <= cnt_out - WIDTH'(1);
            else begin
              tc <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              cnt_out <= rld;
`else
              cnt_out <= '0;
              state   <= EXPIRED;
`endif
            end
          end
          EXPIRED: if (ack) begin
            state   <= IDLE;
            cnt_out <= rld;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus, per-cycle model compare plus literal checks
module tb_countdown_timer;
  logic clk = 0, rst = 0, load = 0, start = 0, enab = 0, ack = 0;
  logic [4:0] cnt_in = 0, cnt_out;
  logic busy, expired, tc;
  int vec = 0, bad = 0;
  countdown_timer #(.WIDTH(5)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .load(load), .start(start), .enab(enab),
    .ack(ack), .cnt_out(cnt_out), .busy(busy), .expired(expired), .tc(tc)
  );
  always #5 clk = ~clk;
  localparam int MI = 0, MR = 1, ME = 2;
  int m_st;
  int m_cnt, m_rld;
  logic m_tc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st <= MI; m_cnt <= 0; m_rld <= 0; m_tc <= 0;
    end else begin
      m_tc <= !load && ((m_st == MI && start && m_cnt == 0) || (m_st == MR && enab && m_cnt == 1));
      if (load) begin
        m_st <= MI; m_cnt <= int'(cnt_in); m_rld <= int'(cnt_in);
      end else if (m_st == MI && start) m_st <= (m_cnt == 0) ? ME : MR;
      else if (m_st == MR && enab) begin
        if (m_cnt == 1) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
          m_cnt <= m_rld;
`else
          m_cnt <= 0; m_st <= ME;
`endif
        end else m_cnt <= m_cnt - 1;
      end else if (m_st == ME && ack) begin
        m_st <= MI; m_cnt <= m_rld;
      end
    end
  end
  always @(negedge clk) begin
    vec++;
    if (int'(cnt_out) != m_cnt || busy != (m_st == MR) || expired != (m_st == ME) || tc != m_tc) begin
      bad++;
      $display("FAIL model t=%0t cnt/busy/exp/tc got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
               $time, cnt_out, busy, expired, tc, m_cnt, m_st == MR, m_st == ME, m_tc);
    end
  end
  task automatic chk(input string n, input int got, input int exp);
    vec++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got %0d want %0d", n, got, exp);
    end
  endtask
  task automatic drive(input logic ld, input logic st, input logic en, input logic ak, input int d);
    load = ld; start = st; enab = en; ack = ak; cnt_in = 5'(d);
    @(negedge clk);
    load = 0; start = 0; enab = 0; ack = 0;
  endtask
  task automatic chk_all(input string n, input int c, input int b, input int e, input int t);
    chk({n, " cnt"}, int'(cnt_out), c);
    chk({n, " busy"}, int'(busy), b);
    chk({n, " expired"}, int'(expired), e);
    chk({n, " tc"}, int'(tc), t);
  endtask
  initial begin
    int ar_cnt[6] = '{1, 2, 1, 2, 1, 2};
    int ar_tc[6] = '{0, 1, 0, 1, 0, 1};
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0);
    rst = 1;
    drive(1, 0, 0, 0, 3);  chk_all("load3", 3, 0, 0, 0);
    drive(0, 1, 0, 0, 0);  chk_all("start3", 3, 1, 0, 0);
    drive(0, 0, 1, 0, 0);  chk("run 2", int'(cnt_out), 2);
    drive(0, 0, 1, 0, 0);  chk("run 1", int'(cnt_out), 1);
    drive(0, 0, 1, 0, 0);
`ifdef COUNTDOWN_AUTORELOAD_EN
    chk_all("reload3", 3, 1, 0, 1);
    drive(0, 0, 0, 0, 0);  chk("tc drop", int'(tc), 0);
    drive(1, 0, 0, 0, 2);
`else
    chk_all("expire3", 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0);  chk_all("hold exp", 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);  chk_all("ack3", 3, 0, 0, 0);
    drive(1, 0, 0, 0, 2);
`endif
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);  chk("gap e1", int'(cnt_out), 1);
    drive(0, 0, 0, 0, 0);  chk("gap e0a", int'(cnt_out), 1);
    drive(0, 0, 0, 0, 0);  chk_all("gap e0b", 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
`ifdef COUNTDOWN_AUTORELOAD_EN
    chk_all("gap end", 2, 1, 0, 1);
`else
    chk_all("gap end", 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
`endif
    drive(1, 0, 0, 0, 4);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);  chk_all("start in run", 4, 1, 0, 0);
    drive(0, 0, 0, 1, 0);  chk_all("ack in run", 4, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);  chk("at one", int'(cnt_out), 1);
    drive(1, 0, 1, 0, 5);  chk_all("load beats tc", 5, 0, 0, 0);
    drive(0, 0, 0, 1, 0);  chk_all("ack in idle", 5, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);  chk_all("start zero", 0, 0, 1, 1);
    drive(0, 0, 1, 0, 0);  chk_all("enab in exp", 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);  chk_all("ack zero", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 2);
    drive(0, 1, 0, 0, 0);
`ifdef COUNTDOWN_AUTORELOAD_EN
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 0, 0);
      chk("autoreload cnt", int'(cnt_out), ar_cnt[i]);
      chk("autoreload tc", int'(tc), ar_tc[i]);
      chk("autoreload exp", int'(expired), 0);
    end
`else
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);  chk_all("oneshot2", 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);  chk("ack2", int'(cnt_out), 2);
`endif
    drive(1, 0, 0, 0, 4);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    load = 0; enab = 1;
    @(posedge clk);
    #3 rst = 0;
    #1 chk_all("async reset", 0, 0, 0, 0);
    enab = 0;
    @(negedge clk);
    rst = 1;
    drive(0, 1, 0, 0, 0);  chk_all("post reset start", 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);  chk_all("post reset ack", 0, 0, 0, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
